// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide controller.
// Holds op encodings, FSM state encoding and default cycle counts.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;
    localparam int CNT_W           = 16;

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// Divide-by-zero is only flagged here; the policy lives in the top.
module muldiv_arith
    import muldiv_pkg::*;
(
    input  op_e         i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_hi_res,
    output logic [31:0] o_lo_res,
    output logic        o_div0
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    // Full-width products; sign extension to 64 bits keeps the low
    // 64 bits of the signed product exact.
    assign w_prod_s = 64'($signed({{32{i_a[31]}}, i_a})
                    * $signed({{32{i_b[31]}}, i_b}));
    assign w_prod_u = {32'b0, i_a} * {32'b0, i_b};

    // Signed divide runs on magnitudes; -0x80000000 wraps to itself,
    // which makes the 0x80000000 / -1 case fall out naturally.
    assign w_a_neg = i_a[31] & (i_op == OP_DIV);
    assign w_b_neg = i_b[31] & (i_op == OP_DIV);
    assign w_mag_a = w_a_neg ? (~i_a + 32'd1) : i_a;
    assign w_mag_b = w_b_neg ? (~i_b + 32'd1) : i_b;
    assign w_div_b = (i_b == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq    = w_mag_a / w_div_b;
    assign w_ur    = w_mag_a % w_div_b;
    assign w_sq    = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
    assign w_sr    = w_a_neg ? (~w_ur + 32'd1) : w_ur;

    assign o_div0  = is_div(i_op) & (i_b == 32'd0);

    // Select the result pair for the latched operation.
    always_comb begin
        o_hi_res = w_prod_s[63:32];
        o_lo_res = w_prod_s[31:0];
        unique case (i_op)
            OP_MULT: begin
                o_hi_res = w_prod_s[63:32];
                o_lo_res = w_prod_s[31:0];
            end
            OP_MULTU: begin
                o_hi_res = w_prod_u[63:32];
                o_lo_res = w_prod_u[31:0];
            end
            OP_DIV: begin
                o_hi_res = o_div0 ? 32'd0 : w_sr;
                o_lo_res = o_div0 ? 32'd0 : w_sq;
            end
            OP_DIVU: begin
                o_hi_res = o_div0 ? 32'd0 : w_ur;
                o_lo_res = o_div0 ? 32'd0 : w_uq;
            end
            default: begin
                o_hi_res = 32'd0;
                o_lo_res = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// Optional MULDIV_DIVZERO_TRAP_EN adds a div0 output and trap behaviour.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
`ifdef MULDIV_DIVZERO_TRAP_EN
    output logic        div0,
`endif
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] L_MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] L_DIV_N  = CNT_W'(DIV_CYCLES);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    op_e              r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_done;
`ifdef MULDIV_DIVZERO_TRAP_EN
    logic             r_div0;
`endif

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_launch;
    logic             w_finish;
    logic [31:0]      w_hi_res;
    logic [31:0]      w_lo_res;
    logic             w_div0;
    logic [31:0]      w_hi_new;
    logic [31:0]      w_lo_new;
    logic             w_mt_ok;

    muldiv_arith u_arith (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_hi_res (w_hi_res),
        .o_lo_res (w_lo_res),
        .o_div0   (w_div0)
    );

`ifdef MULDIV_DIVZERO_TRAP_EN
    assign w_hi_new = w_div0 ? r_hi : w_hi_res;
    assign w_lo_new = w_div0 ? r_lo : w_lo_res;
`else
    assign w_hi_new = w_div0 ? r_a : w_hi_res;
    assign w_lo_new = w_div0 ? 32'hFFFF_FFFF : w_lo_res;
`endif

    // A launch in the same cycle drops any mthi/mtlo strobes.
    assign w_mt_ok = (r_state == S_IDLE) & ~start;

    // Next-state and counter logic: launch from IDLE, count down in BUSY.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = op[1] ? L_DIV_N : L_MULT_N;
                end
            end
            S_BUSY: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state and cycle counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operand latch, HI/LO update and completion pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= OP_MULT;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            r_div0 <= 1'b0;
`endif
        end else begin
            r_done <= w_finish;
`ifdef MULDIV_DIVZERO_TRAP_EN
            r_div0 <= w_finish & w_div0;
`endif
            if (w_launch) begin
                r_op <= op_e'(op);
                r_a  <= a;
                r_b  <= b;
            end
            if (w_finish) begin
                r_hi <= w_hi_new;
                r_lo <= w_lo_new;
            end else if (w_mt_ok) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
        end
    end

    assign busy = (r_state == S_BUSY);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
    assign div0 = r_div0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus
// randomized ops against an arithmetic reference of HI/LO.
module tb_muldiv_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
    logic        div0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
`ifdef MULDIV_DIVZERO_TRAP_EN
        .div0  (div0),
`endif
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference {hi,lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'd0) begin
            res = sx * sy;
        end else if (o == 2'd1) begin
            res = {32'b0, x} * {32'b0, y};
        end else if (y == 32'd0) begin
`ifdef MULDIV_DIVZERO_TRAP_EN
            res = {m_hi, m_lo};
`else
            res = {x, 32'hFFFF_FFFF};
`endif
        end else if (o == 2'd2) begin
            q   = sx / sy;
            r   = sx % sy;
            res = {r[31:0], q[31:0]};
        end else begin
            res = {x % y, x / y};
        end
        return res;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit poke_start,
                         input bit poke_mt, input bit wr_with_start,
                         input string tag);
        logic [63:0] exp;
        int          n;
        int          ncyc;
        exp  = ref_result(o, x, y);
        ncyc = o[1] ? DC : MC;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        hi_we = wr_with_start;
        lo_we = wr_with_start;
        wdata = $urandom;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
        n     = 0;
        while (busy && n < 200) begin
            n++;
            check({tag, "_done_in_busy"}, 64'(done), 64'd0);
            check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
`ifdef MULDIV_DIVZERO_TRAP_EN
            check({tag, "_div0_in_busy"}, 64'(div0), 64'd0);
`endif
            if (poke_start && n == 3) begin
                start = 1'b1;
                op    = 2'b00;
                a     = $urandom;
                b     = $urandom;
            end
            if (poke_mt && n == 2) begin
                lo_we = 1'b1;
                wdata = 32'h55;
            end
            @(negedge clk);
            start = 1'b0;
            lo_we = 1'b0;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(ncyc));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hilo"}, {hi, lo}, exp);
`ifdef MULDIV_DIVZERO_TRAP_EN
        check({tag, "_div0"}, 64'(div0), 64'(o[1] && y == 32'd0));
`endif
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        @(negedge clk);
        check({tag, "_done_once"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic mt(input bit hw, input bit lw, input logic [31:0] d,
                      input string tag);
        @(negedge clk);
        hi_we = hw;
        lo_we = lw;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        check(tag, {hi, lo}, {m_hi, m_lo});
    endtask

    task automatic reset_mid_div();
        bit seen_done;
        @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset     = 1'b0;
        m_hi      = '0;
        m_lo      = '0;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen_done |= done;
        end
        check("rst_no_done", 64'(seen_done), 64'd0);
        check("rst_hilo_after", {hi, lo}, 64'd0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        do_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "mult");
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, "multu");
        check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 0, 0, "div");
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_ovf");
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        mt(1'b1, 1'b0, 32'h1234, "mthi");
        check("mthi_const", 64'(hi), 64'h1234);
        do_op(2'b00, 32'd3, 32'd4, 0, 1, 0, "mtlo_busy");
        check("mtlo_busy_const", {hi, lo}, 64'h0000_0000_0000_000C);
        mt(1'b1, 1'b1, 32'hCAFE_F00D, "mt_both");
        do_op(2'b11, 32'd100, 32'd7, 0, 0, 1, "start_wr");

        reset_mid_div();

        mt(1'b1, 1'b0, 32'hAAAA, "mthi_pre");
        mt(1'b0, 1'b1, 32'h5555, "mtlo_pre");
        do_op(2'b11, 32'h1234_5678, 32'd0, 0, 0, 0, "divu0");
`ifdef MULDIV_DIVZERO_TRAP_EN
        check("divu0_const", {hi, lo}, 64'h0000_AAAA_0000_5555);
`else
        check("divu0_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
`endif
        do_op(2'b10, 32'hFFFF_0000, 32'd0, 0, 0, 0, "div0_s");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                mt($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom, "rnd_mt");
            end else begin
                ro = 2'($urandom);
                rx = $urandom;
                case ($urandom_range(0, 3))
                    0: ry = 32'd0;
                    1: ry = 32'($urandom_range(1, 9));
                    2: ry = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
                    default: ry = $urandom;
                endcase
                do_op(ro, rx, ry, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
